// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a baud-rate serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BAUD      = 115_200,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_LOG2:0]   level,
    output logic                 busy,
    output logic                 ovf,
    input  logic                 ovf_clr,
    output logic                 tx
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int BW    = $clog2(DIV);
    localparam int LW    = FIFO_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [LW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]         r_level, w_level_nxt;
    logic                  r_full, r_empty, r_ovf;
    logic [BW-1:0]         r_baud;
    logic [7:0]            r_shift;
    logic [2:0]            r_bit;
    logic                  w_pop, w_push, w_bit_end, w_tx;
    logic [7:0]            w_head;
`ifdef UART_TX_PARITY_EN
    logic                  r_par;
`endif

    assign w_head      = r_mem[r_rd_ptr[FIFO_LOG2-1:0]];
    assign w_bit_end   = (r_baud == '0);
    // A full FIFO still accepts a write on the cycle the serialiser pops.
    assign w_push      = wr_en && (!r_full || w_pop);
    assign w_level_nxt = r_level + {{FIFO_LOG2{1'b0}}, w_push} - {{FIFO_LOG2{1'b0}}, w_pop};

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr[FIFO_LOG2-1:0]] <= wr_data;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + LW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + LW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
            if (wr_en && r_full && !w_pop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx        = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end)
                    w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end && r_bit == 3'd7)
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx = r_par;
                if (w_bit_end)
                    w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Chain straight into the next frame when data is waiting.
                if (w_bit_end) begin
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_baud  <= '0;
            r_shift <= '0;
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            if (w_pop) begin
                r_shift <= w_head;
                r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
                r_par   <= ^w_head;
`endif
            end else if (r_state == S_DATA && w_bit_end) begin
                r_shift <= {1'b0, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (w_state_nxt == S_IDLE)
                r_baud <= '0;
            else if (w_state_nxt != r_state || w_bit_end)
                r_baud <= BW'(DIV - 1);
            else
                r_baud <= r_baud - BW'(1);
        end
    end

    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_level;
    assign busy  = (r_state != S_IDLE);
    assign ovf   = r_ovf;
    assign tx    = w_tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised + directed bench for uart_tx_fifo (8N1 build, DIV=4, depth 4)
// against a frame-timeline model of the line and a byte queue for the FIFO.
module tb_uart_tx_fifo;
    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       full, empty, busy, ovf, tx;
    logic [2:0] level;

    uart_tx_fifo #(.CLK_HZ(400), .BAUD(100), .FIFO_LOG2(2)) dut (
        .CLK(CLK), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .busy(busy),
        .ovf(ovf), .ovf_clr(ovf_clr), .tx(tx)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Model: queued bytes, byte on the line, cycles left in the current frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    int         m_rem;
    logic       m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_cur = '0;
        m_rem = 0;
        m_ovf = 1'b0;
    endtask

    function automatic logic m_tx();
        int k;
        if (m_rem == 0) return 1'b1;
        k = (FRAME - m_rem) / DIV;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    task automatic m_step();
        logic pop, push, oset;
        if (!resetn) begin
            m_reset();
            return;
        end
        pop  = (m_q.size() > 0) && (m_rem <= 1);
        push = wr_en && (m_q.size() < DEPTH || pop);
        oset = wr_en && (m_q.size() == DEPTH) && !pop;
        if (pop) begin
            m_cur = m_q.pop_front();
            m_rem = FRAME;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (push) m_q.push_back(wr_data);
        if (oset) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic compare();
        if (!resetn) return;
        chk("tx",    32'(tx),    32'(m_tx()));
        chk("busy",  32'(busy),  32'(m_rem != 0));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("full",  32'(full),  32'(m_q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("ovf",   32'(ovf),   32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge CLK);
        m_step();
        @(negedge CLK);
        compare();
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (m_rem != 0 || m_q.size() != 0); i++) tick();
        tick();
        chk("drain_busy", 32'(busy), 32'(0));
        chk("drain_empty", 32'(empty), 32'(1));
    endtask

    initial begin
        logic [9:0] exp_a5;
        logic [9:0] got_a5;
        int run, gap;
        m_reset();
        wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        chk("rst_tx", 32'(tx), 32'(1));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        repeat (3) @(negedge CLK);
        resetn = 1'b1;

        // Idle line after reset
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_tx", 32'(tx), 32'(1));
        end

        // Single byte 0xA5, one sample per bit
        exp_a5 = 10'b1101001010;  // index b = bit b of the line: 0,1,0,1,0,0,1,0,1,1
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        tick();
        got_a5 = '0;
        for (int k = 0; k < FRAME; k++) begin
            if (k % DIV == 0) got_a5[k / DIV] = tx;
            if (k != FRAME - 1) tick();
        end
        chk("a5_bits", 32'(got_a5), 32'(exp_a5));
        tick();
        chk("a5_busy_after", 32'(busy), 32'(0));

        // Back-to-back frames 0x00, 0xFF
        wr_en = 1'b1; wr_data = 8'h00;
        tick();
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        run = busy ? 1 : 0;
        gap = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (busy && gap == 0) run++;
            else gap = 1;
        end
        chk("b2b_len", 32'(run), 32'(2 * FRAME));

        // Five writes from idle, then overflow, then clear
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            tick();
        end
        chk("fill_level", 32'(level), 32'(4));
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_ovf", 32'(ovf), 32'(0));
        chk("model_level", 32'(m_q.size()), 32'(4));
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("ovf_set", 32'(ovf), 32'(1));
        chk("ovf_level", 32'(level), 32'(4));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'(0));

        // Write on the pop cycle while full
        for (int i = 0; i < 200 && m_rem != 1; i++) tick();
        chk("pop_wait", 32'(m_rem), 32'(1));
        chk("pop_full", 32'(full), 32'(1));
        wr_en = 1'b1; wr_data = 8'hC3;
        tick();
        wr_en = 1'b0;
        chk("pop_wr_level", 32'(level), 32'(4));
        chk("pop_wr_ovf", 32'(ovf), 32'(0));
        drain();

        // Reset in the middle of 0x3C with another byte queued
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        repeat (10) tick();
        chk("mid_busy", 32'(busy), 32'(1));
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'(1));
        chk("mid_rst_empty", 32'(empty), 32'(1));
        chk("mid_rst_level", 32'(level), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        m_reset();
        tick();
        resetn = 1'b1;
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        drain();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 15) == 0);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        wr_en = 1'b0; ovf_clr = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
